// File: rtl/mon_pkg.sv
// Shared types and default constants for the result mailbox monitor.
package mon_pkg;

    // Monitor life cycle: IDLE until started, RUN while snooping, then one terminal state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_e;

    localparam logic [31:0] DEF_RESULT_BASE = 32'h0000_0100;
    localparam int          DEF_NUM_SLOTS   = 13;
    localparam logic [31:0] DEF_DONE_ADDR   = 32'h0000_0134;
    localparam logic [4:0]  NO_FAIL_IDX     = 5'd31;

endpackage : mon_pkg

// File: rtl/mon_slot_decode.sv
// Combinational decode of a snooped write: result-region hit, word alignment,
// slot index and done-mailbox hit.
module mon_slot_decode #(
    parameter logic [31:0] RESULT_BASE = 32'h0000_0100,
    parameter int          NUM_SLOTS   = 13,
    parameter logic [31:0] DONE_ADDR   = 32'h0000_0134
) (
    input  logic [31:0] addr,
    input  logic [3:0]  wen,
    output logic        region_hit,
    output logic        full_word,
    output logic [4:0]  slot_idx,
    output logic        done_hit
);

    localparam logic [31:0] REGION_SPAN = 32'(4 * NUM_SLOTS);

    logic [31:0] offset_s;
    logic        wr_event_s;

    // Unsigned offset wraps for addresses below the base, so one compare covers both bounds.
    always_comb begin
        wr_event_s = (wen != 4'h0);
        offset_s   = addr - RESULT_BASE;
        region_hit = wr_event_s && (offset_s < REGION_SPAN);
        full_word  = (wen == 4'hF) && (addr[1:0] == 2'b00);
        slot_idx   = offset_s[6:2];
        done_hit   = wr_event_s && (addr == DONE_ADDR);
    end

endmodule : mon_slot_decode

// File: rtl/result_mailbox_monitor.sv
// Snoop monitor on the CPU data-memory write port: records per-slot verdicts in
// the result mailbox region and ends the run on a done-mailbox write or timeout.
module result_mailbox_monitor
    import mon_pkg::*;
#(
    parameter logic [31:0] RESULT_BASE    = DEF_RESULT_BASE,
    parameter int          NUM_SLOTS      = DEF_NUM_SLOTS,
    parameter logic [31:0] DONE_ADDR      = RESULT_BASE + 32'(4 * NUM_SLOTS),
    parameter int          TIMEOUT_CYCLES = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          d_mem_addr,
    input  logic [31:0]          d_mem_wdata,
    input  logic [3:0]           d_mem_wen,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 pass,
    output logic [NUM_SLOTS-1:0] written_mask,
    output logic [NUM_SLOTS-1:0] fail_mask,
    output logic [4:0]           first_fail_idx,
    output logic                 proto_err,
    output logic [31:0]          cycle_count
);

    localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

    mon_state_e           state_r, state_nxt_s;
    logic [31:0]          cycle_r, cycle_nxt_s;
    logic [NUM_SLOTS-1:0] written_r, written_nxt_s;
    logic [NUM_SLOTS-1:0] fail_r, fail_nxt_s;
    logic                 proto_r, proto_nxt_s;
    logic                 done_r, done_nxt_s;
    logic                 timeout_r, timeout_nxt_s;
    logic                 pass_r, pass_nxt_s;
    logic [4:0]           ffi_r, ffi_nxt_s;
    logic                 region_hit_s, full_word_s, done_hit_s, run_s, slot_wr_s;
    logic [4:0]           slot_idx_s;

    // Lowest failing slot index, or NO_FAIL_IDX when every verdict is clean.
    function automatic logic [4:0] lowest_fail(input logic [NUM_SLOTS-1:0] mask);
        logic [4:0] idx;
        idx = NO_FAIL_IDX;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    mon_slot_decode #(
        .RESULT_BASE (RESULT_BASE),
        .NUM_SLOTS   (NUM_SLOTS),
        .DONE_ADDR   (DONE_ADDR)
    ) u_decode (
        .addr       (d_mem_addr),
        .wen        (d_mem_wen),
        .region_hit (region_hit_s),
        .full_word  (full_word_s),
        .slot_idx   (slot_idx_s),
        .done_hit   (done_hit_s)
    );

    // Next-state, verdict and flag computation; derived outputs are computed from
    // next values so they register in the same cycle as the masks.
    always_comb begin
        state_nxt_s   = state_r;
        cycle_nxt_s   = cycle_r;
        done_nxt_s    = done_r;
        timeout_nxt_s = timeout_r;
        run_s         = (state_r == ST_RUN);
        slot_wr_s     = run_s && region_hit_s;
        written_nxt_s = written_r;
        fail_nxt_s    = fail_r;

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_wr_s && (slot_idx_s == 5'(i))) begin
                written_nxt_s[i] = written_r[i] | full_word_s;
                fail_nxt_s[i]    = full_word_s ? (d_mem_wdata != 32'h0) : 1'b1;
            end else begin
                written_nxt_s[i] = written_r[i];
                fail_nxt_s[i]    = fail_r[i];
            end
        end
        proto_nxt_s = proto_r | (slot_wr_s & ~full_word_s);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    cycle_nxt_s = 32'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A done write on the final cycle beats the timeout.
                if (done_hit_s) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end else if (cycle_r == LAST_CYCLE) begin
                    state_nxt_s   = ST_TIMEOUT;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cycle_nxt_s = cycle_r + 32'd1;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                state_nxt_s = state_r;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        pass_nxt_s = done_nxt_s & (&written_nxt_s) & ~(|fail_nxt_s) & ~proto_nxt_s;
        ffi_nxt_s  = lowest_fail(fail_nxt_s);
    end

    // State and output registers with synchronous reset; reset discards any coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cycle_r   <= 32'd0;
            written_r <= '0;
            fail_r    <= '0;
            proto_r   <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            pass_r    <= 1'b0;
            ffi_r     <= NO_FAIL_IDX;
        end else begin
            state_r   <= state_nxt_s;
            cycle_r   <= cycle_nxt_s;
            written_r <= written_nxt_s;
            fail_r    <= fail_nxt_s;
            proto_r   <= proto_nxt_s;
            done_r    <= done_nxt_s;
            timeout_r <= timeout_nxt_s;
            pass_r    <= pass_nxt_s;
            ffi_r     <= ffi_nxt_s;
        end
    end

    assign busy           = (state_r == ST_RUN);
    assign done           = done_r;
    assign timeout        = timeout_r;
    assign pass           = pass_r;
    assign written_mask   = written_r;
    assign fail_mask      = fail_r;
    assign first_fail_idx = ffi_r;
    assign proto_err      = proto_r;
    assign cycle_count    = cycle_r;

endmodule : result_mailbox_monitor

// File: doc/result_mailbox_monitor.md
# result_mailbox_monitor

Synthesizable snoop monitor on the CPU data-memory write port (downstream of `cpu_top`'s `d_mem_*` outputs, alongside the data RAM model). It captures word writes into the test-result mailbox region, tracks per-slot pass/fail (value 0 = pass), and ends the run on a write to the done mailbox or on a cycle timeout. It replaces fixed-cycle end-of-sim checks in the branch/ALU benches and can be placed on FPGA builds to drive status LEDs.

## Interface
Parameters:
- `RESULT_BASE`, 32'h0000_0100, byte address of slot 0
- `NUM_SLOTS`, 13, number of result words (slot i at `RESULT_BASE + 4*i`), 1..32
- `DONE_ADDR`, `RESULT_BASE + 4*NUM_SLOTS` (0x134), done mailbox address
- `TIMEOUT_CYCLES`, 2000, RUN cycles before timeout, >= 2

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  pulse: leave IDLE, begin counting
- `d_mem_addr`  in  32  snooped data address
- `d_mem_wdata`  in  32  snooped write data
- `d_mem_wen`  in  4  snooped byte write enables
- `busy`  out  1  state == RUN
- `done`  out  1  sticky, done mailbox written
- `timeout`  out  1  sticky, timeout reached
- `pass`  out  1  valid when `done`; all slots written, all zero, no protocol error
- `written_mask`  out  NUM_SLOTS  slot has received a full-word write
- `fail_mask`  out  NUM_SLOTS  last write to slot was non-zero or malformed
- `first_fail_idx`  out  5  lowest set bit of `fail_mask`; 31 if none
- `proto_err`  out  1  sticky, malformed write into region
- `cycle_count`  out  32  RUN cycles elapsed, frozen on exit from RUN

## Operation
- States: IDLE -> RUN on `start`; RUN -> DONE on qualifying done-mailbox write; RUN -> TIMEOUT when `cycle_count == TIMEOUT_CYCLES-1` and no done write that cycle. DONE/TIMEOUT terminal until `rst`. `start` ignored outside IDLE.
- Write event: `d_mem_wen != 0`, sampled only in RUN.
- Region hit: `RESULT_BASE <= addr < RESULT_BASE + 4*NUM_SLOTS`; slot = `(addr - RESULT_BASE) >> 2` (32-bit unsigned subtract).
- Full-word write to slot (wen == 4'hF, addr[1:0] == 0): set `written_mask[slot]`; `fail_mask[slot] = (wdata != 0)`. Later writes overwrite verdict (last write wins).
- Malformed write to slot (wen != 4'hF or addr[1:0] != 0): set `proto_err`, set `fail_mask[slot]`, leave `written_mask` unchanged.
- Done write: addr == DONE_ADDR, any nonzero wen; data ignored.
- `pass = done & &written_mask & ~|fail_mask & ~proto_err`; 0 whenever `done` = 0.
- Writes outside region and DONE_ADDR ignored. Writes in IDLE/DONE/TIMEOUT ignored.
- Simultaneous done write and final timeout cycle: DONE wins, `timeout` stays 0.

## Timing
- Reset values: state IDLE; `busy`, `done`, `timeout`, `pass`, `proto_err` = 0; masks = 0; `first_fail_idx` = 31; `cycle_count` = 0.
- All outputs registered. Write at edge N updates masks/flags visible after edge N (1-cycle latency); `first_fail_idx` and `pass` derived from registers, same cycle as masks.
- `cycle_count` increments each RUN cycle, 0 in first RUN cycle; saturates never (bounded by timeout).
- `rst` mid-RUN: all state cleared at next edge, any coincident write discarded.

## Structure
- Shared package `mon_pkg`: state enum (IDLE, RUN, DONE, TIMEOUT), default `RESULT_BASE`/`DONE_ADDR` constants, `NO_FAIL_IDX` = 5'd31.
- One sub-module natural: `mon_slot_decode` (combinational region/alignment/slot-index decode). Priority encoder for `first_fail_idx` inline.

## Test plan
- Start, write 0 to 0x100..0x130 (13 word writes), then write 1 to 0x134 -> `done`=1, `pass`=1, `written_mask`=13'h1FFF, `fail_mask`=0, `first_fail_idx`=31.
- Write 5 to 0x108 then 0 to 0x108, all others 0, done -> slot 2 pass (last write wins), `pass`=1; variant ending with 5 -> `fail_mask`=13'h0004, `first_fail_idx`=2, `pass`=0.
- wen=4'b0011 to 0x110 -> `proto_err`=1, `fail_mask[4]`=1, `written_mask[4]` unchanged; done -> `pass`=0.
- No done write, TIMEOUT_CYCLES=2000 -> `timeout`=1 after 2000 RUN cycles, `cycle_count`=1999 frozen, `done`=0, `busy`=0.
- Done write on cycle 1999 -> `done`=1, `timeout`=0; writes to 0x100 before `start` and after DONE leave masks unchanged.
- Assert `rst` one cycle mid-RUN with coincident slot write -> all outputs return to reset values, state IDLE.
